// File: rtl/mv_pred_ctrl.sv
// Motion-vector predictor sequencer: fetches three neighbours from the
// vector store, forms the median predictor, writes back and reports MVD.
module mv_pred_ctrl #(
  parameter int BLOCK_ROW = 80,
  parameter int BLOCK_COL = 45
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [13:0] blk_pos,
  input  logic [13:0] best_mv,
  input  logic        best_valid,
  input  logic [13:0] vec_in,
  output logic        feed,
  output logic [13:0] curpos,
  output logic        we,
  output logic [13:0] mv_wr,
  output logic [13:0] pred_mv,
  output logic        pred_valid,
  output logic [13:0] mvd,
  output logic        done,
  output logic        busy
);

  typedef enum logic [3:0] {
    S_IDLE, S_F0, S_F1, S_F2, S_DRAIN,
    S_MED, S_WAIT, S_WR, S_DN
  } state_t;

  state_t state, state_nx;

  logic [13:0] a_q, b_q, c_q;
  logic [13:0] pred_nx;
  logic        a_ok, b_ok, c_ok;

  // Block coordinates are carried in 7-bit fields.
  if (BLOCK_ROW < 1 || BLOCK_ROW > 128 ||
      BLOCK_COL < 2 || BLOCK_COL > 128) begin : g_chk
    $error("block grid does not fit 7-bit coordinates");
  end

  function automatic logic signed [6:0] med3(
    input logic signed [6:0] a,
    input logic signed [6:0] b,
    input logic signed [6:0] c
  );
    logic signed [6:0] lo, hi, m;
    lo = (a < b) ? a : b;
    hi = (a < b) ? b : a;
    m  = (hi < c) ? hi : c;
    return (lo > m) ? lo : m;
  endfunction

  assign a_ok = curpos[6:0] != 7'd0;
  assign b_ok = curpos[13:7] != 7'd0;
  assign c_ok = curpos[13:7] != 7'(BLOCK_COL - 1);

  assign pred_nx = {
    med3(a_q[13:7], b_q[13:7], c_q[13:7]),
    med3(a_q[6:0], b_q[6:0], c_q[6:0])
  };

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    feed     = 1'b0;
    we       = 1'b0;
    done     = 1'b0;
    busy     = 1'b1;
    unique case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) state_nx = S_F0;
      end
      S_F0: begin
        feed     = 1'b1;
        state_nx = S_F1;
      end
      S_F1: begin
        feed     = 1'b1;
        state_nx = S_F2;
      end
      S_F2: begin
        feed     = 1'b1;
        state_nx = S_DRAIN;
      end
      S_DRAIN: state_nx = S_MED;
      S_MED:   state_nx = S_WAIT;
      S_WAIT: begin
        if (best_valid) state_nx = S_WR;
      end
      S_WR: begin
        we       = 1'b1;
        state_nx = S_DN;
      end
      S_DN: begin
        done     = 1'b1;
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // Read data lags the fetch address by one cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      curpos     <= '0;
      a_q        <= '0;
      b_q        <= '0;
      c_q        <= '0;
      pred_mv    <= '0;
      pred_valid <= 1'b0;
      mv_wr      <= '0;
      mvd        <= '0;
    end else begin
      pred_valid <= state == S_MED;
      if (state == S_IDLE && start)
        curpos <= blk_pos;
      if (state == S_F1)
        a_q <= a_ok ? vec_in : '0;
      if (state == S_F2)
        b_q <= b_ok ? vec_in : '0;
      if (state == S_DRAIN)
        c_q <= c_ok ? vec_in : '0;
      if (state == S_MED)
        pred_mv <= pred_nx;
      if (state == S_WAIT && best_valid)
        mv_wr <= best_mv;
      if (state == S_WR)
        mvd <= {mv_wr[13:7] - pred_mv[13:7],
                mv_wr[6:0] - pred_mv[6:0]};
    end
  end

endmodule

// File: tb/tb_mv_pred_ctrl.sv
// Bench for mv_pred_ctrl: vector-store model, cycle-level reference
// of the operation timeline and median/MVD arithmetic.
module tb_mv_pred_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [13:0] blk_pos;
  logic [13:0] best_mv;
  logic        best_valid;
  logic [13:0] vec_in;
  logic        feed;
  logic [13:0] curpos;
  logic        we;
  logic [13:0] mv_wr;
  logic [13:0] pred_mv;
  logic        pred_valid;
  logic [13:0] mvd;
  logic        done;
  logic        busy;

  always #5 clk = ~clk;

  mv_pred_ctrl #(.BLOCK_ROW(80), .BLOCK_COL(45)) dut (
    .clk(clk), .reset(reset), .start(start),
    .blk_pos(blk_pos), .best_mv(best_mv),
    .best_valid(best_valid), .vec_in(vec_in),
    .feed(feed), .curpos(curpos), .we(we),
    .mv_wr(mv_wr), .pred_mv(pred_mv),
    .pred_valid(pred_valid), .mvd(mvd),
    .done(done), .busy(busy)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  logic [13:0] mem [45][80];
  logic [13:0] exp_mem [45][80];
  int fcnt = 0;

  function automatic logic [13:0] st_rd(input int y, input int x);
    if (y < 0 || y > 44 || x < 0 || x > 79) return 14'h2aaa;
    return mem[y][x];
  endfunction

  // Store: counts feed cycles for neighbour addressing, one-cycle read.
  always @(posedge clk) begin
    if (we && curpos[13:7] < 7'd45 && curpos[6:0] < 7'd80)
      mem[curpos[13:7]][curpos[6:0]] <= mv_wr;
    if (feed) begin
      if (fcnt == 0)
        vec_in <= st_rd(int'(curpos[13:7]), int'(curpos[6:0]) - 1);
      else if (fcnt == 1)
        vec_in <= st_rd(int'(curpos[13:7]) - 1, int'(curpos[6:0]));
      else
        vec_in <= st_rd(int'(curpos[13:7]) + 1,
                        (int'(curpos[6:0]) + 2 > 79) ? 79 : int'(curpos[6:0]) + 2);
      fcnt <= fcnt + 1;
    end else begin
      fcnt   <= 0;
      vec_in <= 14'($urandom);
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h cyc=%0d", nm, act, exp, cyc);
    end
  endtask

  function automatic int sx7(input logic [6:0] v);
    return v[6] ? int'(v) - 128 : int'(v);
  endfunction

  function automatic int med(input int a, input int b, input int c);
    int t;
    if (a > b) begin t = a; a = b; b = t; end
    if (b > c) begin t = b; b = c; c = t; end
    if (a > b) begin t = a; a = b; b = t; end
    return b;
  endfunction

  function automatic logic [13:0] vec(input int a, input int b);
    return {7'(a), 7'(b)};
  endfunction

  // Reference state shared between driver and compare process
  int s = 0;
  int b = -1;
  bit op_on = 1'b0;
  bit lit_en = 1'b0;
  logic [13:0] e_pred, e_mvd, e_best, e_pos;
  logic [13:0] lit_pred, lit_mvd;
  logic [13:0] l_pred = '0;
  logic [13:0] l_mvd = '0;

  int r;
  bit e_feed, e_pv, e_we, e_done, e_busy;

  always @(negedge clk) begin
    if (!reset) begin
      r      = cyc - s;
      e_feed = op_on && r >= 0 && r <= 2;
      e_pv   = op_on && r == 5;
      e_we   = op_on && b >= 0 && cyc == b + 1;
      e_done = op_on && b >= 0 && cyc == b + 2;
      e_busy = op_on && (b < 0 || cyc <= b + 2);
      chk("feed", feed, e_feed);
      chk("pred_valid", pred_valid, e_pv);
      chk("we", we, e_we);
      chk("done", done, e_done);
      chk("busy", busy, e_busy);
      if (e_pv) begin
        chk("pred_mv", pred_mv, e_pred);
        if (lit_en) chk("pred_lit", pred_mv, lit_pred);
      end
      if (e_we) begin
        chk("mv_wr", mv_wr, e_best);
        chk("curpos", curpos, e_pos);
      end
      if (e_done) begin
        chk("mvd", mvd, e_mvd);
        if (lit_en) chk("mvd_lit", mvd, lit_mvd);
      end
      if (!op_on) begin
        chk("pred_hold", pred_mv, l_pred);
        chk("mvd_hold", mvd, l_mvd);
      end
    end
  end

  task automatic setv(input int y, input int x, input logic [13:0] v);
    mem[y][x]     = v;
    exp_mem[y][x] = v;
  endtask

  task automatic run_op(
    input logic [13:0] pos, input logic [13:0] best,
    input int k, input bit abuse, input bit lit,
    input logic [13:0] lp, input logic [13:0] lm,
    input bit abort
  );
    int y, x, cx, py, px;
    logic [13:0] av, bv, cv;
    y  = int'(pos[13:7]);
    x  = int'(pos[6:0]);
    cx = (x + 2 > 79) ? 79 : x + 2;
    av = (x == 0) ? 14'h0 : exp_mem[y][x-1];
    bv = (y == 0) ? 14'h0 : exp_mem[y-1][x];
    cv = (y == 44) ? 14'h0 : exp_mem[y+1][cx];
    py = med(sx7(av[13:7]), sx7(bv[13:7]), sx7(cv[13:7]));
    px = med(sx7(av[6:0]), sx7(bv[6:0]), sx7(cv[6:0]));
    e_pred   = {7'(py), 7'(px)};
    e_mvd    = {7'(sx7(best[13:7]) - py), 7'(sx7(best[6:0]) - px)};
    e_best   = best;
    e_pos    = pos;
    lit_en   = lit;
    lit_pred = lp;
    lit_mvd  = lm;
    @(posedge clk); #2;
    blk_pos = pos;
    start   = 1'b1;
    @(posedge clk); #2;
    start   = 1'b0;
    s       = cyc;
    b       = -1;
    op_on   = 1'b1;
    blk_pos = 14'($urandom);
    for (int t = 1; t <= 5 + k; t++) begin
      @(posedge clk); #2;
      start      = abuse && t == 1;
      best_valid = abuse && t == 4;
      best_mv    = 14'($urandom);
    end
    best_valid = 1'b1;
    best_mv    = best;
    b          = cyc;
    @(posedge clk); #2;
    best_valid = 1'b0;
    best_mv    = 14'($urandom);
    if (abort) begin
      chk("we_pre_rst", we, 1);
      reset = 1'b1;
      #1;
      chk("rst_feed", feed, 0);
      chk("rst_we", we, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      op_on  = 1'b0;
      l_pred = '0;
      l_mvd  = '0;
      @(posedge clk); #2;
      chk("rst_done2", done, 0);
      chk("no_write", mem[y][x], exp_mem[y][x]);
      reset = 1'b0;
    end else begin
      @(posedge clk); #2;
      @(posedge clk); #2;
      exp_mem[y][x] = best;
      l_pred        = e_pred;
      l_mvd         = e_mvd;
      op_on         = 1'b0;
    end
  endtask

  initial begin
    reset      = 1'b1;
    start      = 1'b0;
    best_valid = 1'b0;
    blk_pos    = '0;
    best_mv    = '0;
    for (int y = 0; y < 45; y++)
      for (int x = 0; x < 80; x++)
        setv(y, x, 14'($urandom));
    repeat (3) @(posedge clk);
    #1;
    chk("rst_feed0", feed, 0);
    chk("rst_we0", we, 0);
    chk("rst_busy0", busy, 0);
    chk("rst_pv0", pred_valid, 0);
    chk("rst_pred0", pred_mv, 0);
    chk("rst_mvd0", mvd, 0);
    chk("rst_cur0", curpos, 0);
    chk("rst_mvwr0", mv_wr, 0);
    #1;
    reset = 1'b0;

    // Interior block
    setv(10, 19, vec(2, 3));
    setv(9, 20, vec(-1, 5));
    setv(11, 22, vec(4, -2));
    run_op(vec(10, 20), vec(3, 4), 0, 0, 1,
           vec(2, 3), vec(1, 1), 0);

    // Top-left corner
    setv(1, 2, vec(6, 6));
    run_op(vec(0, 0), vec(-64, 63), 2, 0, 1,
           vec(0, 0), vec(-64, 63), 0);

    // Bottom row
    setv(44, 4, vec(1, 1));
    setv(43, 5, vec(5, 5));
    run_op(vec(44, 5), vec(0, 0), 1, 0, 1,
           vec(1, 1), vec(-1, -1), 0);

    // Component wrap
    setv(20, 29, vec(63, -64));
    setv(19, 30, vec(63, -64));
    setv(21, 32, vec(0, 0));
    run_op(vec(20, 30), vec(-64, 63), 0, 0, 1,
           vec(63, -64), vec(1, -1), 0);

    // Stray start / best_valid, late best_valid
    run_op(vec(5, 5), vec(7, -9), 10, 1, 0, '0, '0, 0);

    // Reset during write-back, then a normal operation
    setv(7, 7, 14'h0);
    run_op(vec(7, 7), vec(5, 5), 3, 0, 0, '0, '0, 1);
    run_op(vec(7, 7), vec(5, 5), 0, 0, 0, '0, '0, 0);

    for (int i = 0; i < 40; i++) begin
      run_op(vec($urandom_range(0, 44), $urandom_range(0, 79)),
             14'($urandom), $urandom_range(0, 12),
             1'($urandom_range(0, 1)), 0, '0, '0, 0);
    end

    repeat (4) @(posedge clk);
    #2;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
